// File: rtl/sram_rr_arbiter.sv
// ============================================================================
// sram_rr_arbiter
// ----------------------------------------------------------------------------
// Two-channel arbiter in front of an asynchronous SRAM PHY. Requesters A and B
// share the single SRAM port. At most one access is granted per cycle. The PHY
// drive is fully registered. Read data goes back to the channel that issued
// the read after a fixed latency. Idle PHY cycles are inserted when a read
// follows a write, so the dq bus can turn around.
//
// Configuration macro:
//   SRAM_ARB_FIXED_PRIO_EN  defined   -> channel A always wins simultaneous
//                                        requests (B may starve).
//                           undefined -> round-robin (default).
//
// Parameters:
//   DW      data width
//   AW      address width
//   RD_LAT  cycles from the PHY read cycle to the sram_dq_rd sample (1..4)
//   TURN    idle PHY cycles inserted when a read follows a write (0..3)
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   en                    chip enable; 0 blocks all new grants
//   addr_a/b, wdata_a/b   request address / write data per channel
//   req_a/b, we_a/b       request strobe and direction (1 = write)
//   busy_a/b              request not accepted this cycle (combinational)
//   rdata_a/b, valid_a/b  read return data and one-cycle valid pulse
//   sram_addr             registered PHY address
//   sram_ce_n/we_n/oe_n   registered PHY strobes, active low
//   sram_dq_wr            write data for the top-level tristate
//   sram_dq_oe            1 = top level drives sram_dq_wr onto dq
//   sram_dq_rd            sampled dq input
// ============================================================================
module sram_rr_arbiter #(
    parameter int DW     = 8,
    parameter int AW     = 19,
    parameter int RD_LAT = 1,
    parameter int TURN   = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_a,
    input  logic [DW-1:0] wdata_b,
    input  logic          req_a,
    input  logic          req_b,
    input  logic          we_a,
    input  logic          we_b,
    output logic          busy_a,
    output logic          busy_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b,
    output logic          valid_a,
    output logic          valid_b,
    output logic [AW-1:0] sram_addr,
    output logic          sram_ce_n,
    output logic          sram_we_n,
    output logic          sram_oe_n,
    output logic [DW-1:0] sram_dq_wr,
    output logic          sram_dq_oe,
    input  logic [DW-1:0] sram_dq_rd
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_TURN
    } state_t;

    // The cycle in which a read is held back already yields one idle PHY
    // cycle, so the TURN state only has to cover the remaining TURN-1 cycles.
    localparam logic [1:0] TURN_LOAD = (TURN > 1) ? 2'(TURN - 1) : 2'd0;
    localparam bit         TURN_EN   = (TURN != 0);

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    state_t              state_q,      state_d;
    logic [1:0]          turn_cnt_q,   turn_cnt_d;
`ifndef SRAM_ARB_FIXED_PRIO_EN
    logic                rr_last_b_q,  rr_last_b_d;  // 1 = B was granted last
`endif

    logic [AW-1:0]       sram_addr_q,  sram_addr_d;
    logic                sram_ce_n_q,  sram_ce_n_d;
    logic                sram_we_n_q,  sram_we_n_d;
    logic                sram_oe_n_q,  sram_oe_n_d;
    logic [DW-1:0]       sram_dq_wr_q, sram_dq_wr_d;
    logic                sram_dq_oe_q, sram_dq_oe_d;

    // Read tag pipe: stage 0 lines up with the PHY read cycle.
    logic [RD_LAT-1:0]   rd_v_q,       rd_v_d;
    logic [RD_LAT-1:0]   rd_ch_q,      rd_ch_d;      // 1 = channel B

    logic [DW-1:0]       rdata_a_q,    rdata_a_d;
    logic [DW-1:0]       rdata_b_q,    rdata_b_d;
    logic                valid_a_q,    valid_a_d;
    logic                valid_b_q,    valid_b_d;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    logic elig_a, elig_b;
    logic pick_a, pick_b;
    logic win_we;
    logic phy_wr;
    logic turn_block;
    logic grant_a, grant_b;
    logic grant_any;
    logic grant_we;

    // A PHY write cycle is the only one that drives we_n low.
    assign phy_wr = !sram_we_n_q;

    // NOTE: every signal assigned in an always_comb gets a default at the top
    // of the block; otherwise a path that skips the assignment infers a latch.
    always_comb begin
        elig_a = req_a && en && (state_q != ST_TURN);
        elig_b = req_b && en && (state_q != ST_TURN);

`ifdef SRAM_ARB_FIXED_PRIO_EN
        pick_a = elig_a;
        pick_b = elig_b && !elig_a;
`else
        // On a tie the channel that was not granted last wins.
        pick_a = elig_a && (!elig_b || rr_last_b_q);
        pick_b = elig_b && (!elig_a ||  !rr_last_b_q);
`endif

        win_we = pick_a ? we_a : we_b;

        // A read that wins right behind a PHY write is held off for the
        // turnaround; nobody is granted in that cycle.
        turn_block = TURN_EN && (pick_a || pick_b) && !win_we && phy_wr;

        grant_a   = pick_a && !turn_block;
        grant_b   = pick_b && !turn_block;
        grant_any = grant_a || grant_b;
        grant_we  = grant_a ? we_a : we_b;
    end

    assign busy_a = req_a && !grant_a;
    assign busy_b = req_b && !grant_b;

    // ------------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        turn_cnt_d = turn_cnt_q;

        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (turn_block) begin
                    if (TURN_LOAD != 2'd0) begin
                        state_d    = ST_TURN;
                        turn_cnt_d = TURN_LOAD;
                    end else begin
                        state_d    = ST_RUN;
                    end
                end else if (grant_any) begin
                    state_d = ST_RUN;
                end
            end
            ST_TURN: begin
                if (turn_cnt_q <= 2'd1) begin
                    state_d    = ST_RUN;
                    turn_cnt_d = 2'd0;
                end else begin
                    turn_cnt_d = turn_cnt_q - 2'd1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                turn_cnt_d = 2'd0;
            end
        endcase
    end

`ifndef SRAM_ARB_FIXED_PRIO_EN
    always_comb begin
        rr_last_b_d = rr_last_b_q;
        if (grant_any) begin
            rr_last_b_d = grant_b;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // PHY drive (next cycle)
    // ------------------------------------------------------------------------
    always_comb begin
        // Idle PHY by default; address and write data hold their last value.
        sram_addr_d  = sram_addr_q;
        sram_dq_wr_d = sram_dq_wr_q;
        sram_ce_n_d  = 1'b1;
        sram_we_n_d  = 1'b1;
        sram_oe_n_d  = 1'b1;
        sram_dq_oe_d = 1'b0;

        if (grant_any) begin
            sram_ce_n_d = 1'b0;
            sram_addr_d = grant_a ? addr_a : addr_b;
            if (grant_we) begin
                sram_we_n_d  = 1'b0;
                sram_dq_oe_d = 1'b1;
                sram_dq_wr_d = grant_a ? wdata_a : wdata_b;
            end else begin
                sram_oe_n_d  = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read return
    // ------------------------------------------------------------------------
    logic ret_v;
    logic ret_ch;

    always_comb begin
        rd_v_d     = rd_v_q;
        rd_ch_d    = rd_ch_q;
        rd_v_d[0]  = grant_any && !grant_we;
        rd_ch_d[0] = grant_b;
        for (int i = 1; i < RD_LAT; i++) begin
            rd_v_d[i]  = rd_v_q[i-1];
            rd_ch_d[i] = rd_ch_q[i-1];
        end

        ret_v  = rd_v_q[RD_LAT-1];
        ret_ch = rd_ch_q[RD_LAT-1];

        valid_a_d = ret_v && !ret_ch;
        valid_b_d = ret_v &&  ret_ch;
        rdata_a_d = valid_a_d ? sram_dq_rd : rdata_a_q;
        rdata_b_d = valid_b_d ? sram_dq_rd : rdata_b_q;
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the values from before the edge, independent of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            turn_cnt_q   <= 2'd0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            rr_last_b_q  <= 1'b1;
`endif
            sram_addr_q  <= '0;
            sram_ce_n_q  <= 1'b1;
            sram_we_n_q  <= 1'b1;
            sram_oe_n_q  <= 1'b1;
            sram_dq_wr_q <= '0;
            sram_dq_oe_q <= 1'b0;
            rd_v_q       <= '0;
            rd_ch_q      <= '0;
            rdata_a_q    <= '0;
            rdata_b_q    <= '0;
            valid_a_q    <= 1'b0;
            valid_b_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            turn_cnt_q   <= turn_cnt_d;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            rr_last_b_q  <= rr_last_b_d;
`endif
            sram_addr_q  <= sram_addr_d;
            sram_ce_n_q  <= sram_ce_n_d;
            sram_we_n_q  <= sram_we_n_d;
            sram_oe_n_q  <= sram_oe_n_d;
            sram_dq_wr_q <= sram_dq_wr_d;
            sram_dq_oe_q <= sram_dq_oe_d;
            rd_v_q       <= rd_v_d;
            rd_ch_q      <= rd_ch_d;
            rdata_a_q    <= rdata_a_d;
            rdata_b_q    <= rdata_b_d;
            valid_a_q    <= valid_a_d;
            valid_b_q    <= valid_b_d;
        end
    end

    assign sram_addr  = sram_addr_q;
    assign sram_ce_n  = sram_ce_n_q;
    assign sram_we_n  = sram_we_n_q;
    assign sram_oe_n  = sram_oe_n_q;
    assign sram_dq_wr = sram_dq_wr_q;
    assign sram_dq_oe = sram_dq_oe_q;
    assign rdata_a    = rdata_a_q;
    assign rdata_b    = rdata_b_q;
    assign valid_a    = valid_a_q;
    assign valid_b    = valid_b_q;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// ============================================================================
// tb_sram_rr_arbiter
// ----------------------------------------------------------------------------
// Directed bench for sram_rr_arbiter with default parameters (RD_LAT=1,
// TURN=1). The stimulus pushes expected read returns (channel, data, cycle)
// into a queue; a monitor pops and compares whenever valid_a/valid_b pulses.
// A behavioural SRAM model holds the memory contents.
// ============================================================================
module tb_sram_rr_arbiter;

    localparam int DW     = 8;
    localparam int AW     = 19;
    localparam int RD_LAT = 1;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef struct {
        logic          ch;     // 1 = channel B
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] wdata_a, wdata_b;
    logic          req_a, req_b, we_a, we_b;
    logic          busy_a, busy_b;
    logic [DW-1:0] rdata_a, rdata_b;
    logic          valid_a, valid_b;
    logic [AW-1:0] sram_addr;
    logic          sram_ce_n, sram_we_n, sram_oe_n;
    logic [DW-1:0] sram_dq_wr;
    logic          sram_dq_oe;
    logic [DW-1:0] sram_dq_rd = '0;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t sb_q[$];
    logic [DW-1:0] mem [int];

    sram_rr_arbiter #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT), .TURN(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .addr_a     (addr_a),
        .addr_b     (addr_b),
        .wdata_a    (wdata_a),
        .wdata_b    (wdata_b),
        .req_a      (req_a),
        .req_b      (req_b),
        .we_a       (we_a),
        .we_b       (we_b),
        .busy_a     (busy_a),
        .busy_b     (busy_b),
        .rdata_a    (rdata_a),
        .rdata_b    (rdata_b),
        .valid_a    (valid_a),
        .valid_b    (valid_b),
        .sram_addr  (sram_addr),
        .sram_ce_n  (sram_ce_n),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n),
        .sram_dq_wr (sram_dq_wr),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_rd (sram_dq_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------------
    // SRAM model: writes commit at the end of a PHY write cycle; read data is
    // presented mid-cycle during a PHY read cycle.
    // ------------------------------------------------------------------------
    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        return mem.exists(int'(a)) ? mem[int'(a)] : '0;
    endfunction

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) mem[int'(sram_addr)] = sram_dq_wr;
    end

    always @(negedge clk) begin
        sram_dq_rd = (!sram_ce_n && !sram_oe_n) ? mem_rd(sram_addr) : '0;
    end

    // ------------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: every valid pulse must match the head of the scoreboard.
    task automatic pop_cmp(input logic ch, input logic [DW-1:0] data);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_valid: got valid on ch %0d data 0x%0h with nothing expected (cycle %0d)",
                     ch, data, cyc);
        end else begin
            e = sb_q.pop_front();
            check("ret_channel", 32'(ch),   32'(e.ch));
            check("ret_data",    32'(data), 32'(e.data));
            check("ret_cycle",   32'(cyc),  32'(e.cyc));
        end
    endtask

    always @(negedge clk) begin
        if (valid_a && valid_b) begin
            check("valid_both", 32'(valid_a && valid_b), 32'd0);
        end else if (valid_a) begin
            pop_cmp(1'b0, rdata_a);
        end else if (valid_b) begin
            pop_cmp(1'b1, rdata_b);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic ch, input logic [DW-1:0] data);
        exp_t e;
        e.ch   = ch;
        e.data = data;
        e.cyc  = cyc + RD_LAT + 1;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb_q.size() != 0; k++) step();
        check("drain_pending", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic apply_reset();
        rst   = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        step();
        step();
        rst   = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        logic          exp_a_win;
        logic [AW-1:0] prev_addr;
        int            na, nb;

        rst = 1'b1; en = 1'b1;
        req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
        addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;

        for (int k = 0; k < 6; k++) begin
            mem[32'h100 + k] = 8'h10 + 8'(k);
            mem[32'h200 + k] = 8'h80 + 8'(k);
        end
        mem[32'h300]   = 8'h33;
        mem[32'h7FFFF] = 8'hA5;

        // Reset held three cycles.
        repeat (3) step();
        check("rst_ce_n",   32'(sram_ce_n),  32'd1);
        check("rst_we_n",   32'(sram_we_n),  32'd1);
        check("rst_oe_n",   32'(sram_oe_n),  32'd1);
        check("rst_dq_oe",  32'(sram_dq_oe), 32'd0);
        check("rst_addr",   32'(sram_addr),  32'd0);
        check("rst_dq_wr",  32'(sram_dq_wr), 32'd0);
        check("rst_busy_a", 32'(busy_a),     32'd0);
        check("rst_busy_b", 32'(busy_b),     32'd0);
        check("rst_valid",  32'({valid_a, valid_b}), 32'd0);
        rst = 1'b0;

        // Write 0x55 @ 0x00010, then read it back through the turnaround.
        step();
        req_a = 1'b1; we_a = 1'b1; addr_a = 19'h00010; wdata_a = 8'h55;
        #1 check("wr_busy_a", 32'(busy_a), 32'd0);
        step();
        we_a = 1'b0;
        #1;
        check("turn_busy_a", 32'(busy_a),     32'd1);
        check("wr_we_n",     32'(sram_we_n),  32'd0);
        check("wr_oe_n",     32'(sram_oe_n),  32'd1);
        check("wr_dq_oe",    32'(sram_dq_oe), 32'd1);
        check("wr_dq_wr",    32'(sram_dq_wr), 32'h55);
        check("wr_addr",     32'(sram_addr),  32'h10);
        step();
        #1;
        check("turn_idle_ce_n", 32'(sram_ce_n), 32'd1);
        check("turn_idle_we_n", 32'(sram_we_n), 32'd1);
        check("rd_busy_a",      32'(busy_a),    32'd0);
        push_exp(1'b0, 8'h55);
        step();
        req_a = 1'b0;
        #1;
        check("rd_oe_n",  32'(sram_oe_n),  32'd0);
        check("rd_ce_n",  32'(sram_ce_n),  32'd0);
        check("rd_dq_oe", 32'(sram_dq_oe), 32'd0);
        drain();

        // Both channels read for six cycles.
        apply_reset();
        na = 0; nb = 0; prev_addr = '0;
        for (int i = 0; i < 6; i++) begin
            step();
            req_a = 1'b1; we_a = 1'b0; addr_a = 19'h100 + 19'(na);
            req_b = 1'b1; we_b = 1'b0; addr_b = 19'h200 + 19'(nb);
            #1;
            if (i > 0) check("rr_phy_addr", 32'(sram_addr), 32'(prev_addr));
            exp_a_win = FIXED || (i % 2 == 0);
            check("rr_busy_a", 32'(busy_a), 32'(!exp_a_win));
            check("rr_busy_b", 32'(busy_b), 32'(exp_a_win));
            if (exp_a_win) begin
                push_exp(1'b0, 8'h10 + 8'(na));
                prev_addr = addr_a;
                na++;
            end else begin
                push_exp(1'b1, 8'h80 + 8'(nb));
                prev_addr = addr_b;
                nb++;
            end
        end
        step();
        req_a = 1'b0; req_b = 1'b0;
        drain();

        // Reset lands one cycle after a read grant: the read is dropped.
        step();
        req_a = 1'b1; we_a = 1'b0; addr_a = 19'h300;
        #1 check("rstmid_busy_a", 32'(busy_a), 32'd0);
        step();
        req_a = 1'b0; rst = 1'b1;
        #1 check("rstmid_oe_n", 32'(sram_oe_n), 32'd0);
        step();
        check("rstmid_ce_n",  32'(sram_ce_n), 32'd1);
        check("rstmid_oe_n2", 32'(sram_oe_n), 32'd1);
        check("rstmid_valid", 32'({valid_a, valid_b}), 32'd0);
        rst = 1'b0;
        step();
        check("rstmid_valid2", 32'({valid_a, valid_b}), 32'd0);
        check("rstmid_ce_n2",  32'(sram_ce_n), 32'd1);

        // en low blocks the request; top address read once enabled, and the
        // in-flight read still returns after en drops again.
        step();
        en = 1'b0; req_a = 1'b1; we_a = 1'b0; addr_a = 19'h7FFFF;
        #1 check("en0_busy_a", 32'(busy_a), 32'd1);
        step();
        #1;
        check("en0_ce_n",    32'(sram_ce_n), 32'd1);
        check("en0_busy_a2", 32'(busy_a),    32'd1);
        en = 1'b1;
        #1 check("en1_busy_a", 32'(busy_a), 32'd0);
        push_exp(1'b0, 8'hA5);
        step();
        req_a = 1'b0; en = 1'b0;
        #1;
        check("top_addr", 32'(sram_addr), 32'h7FFFF);
        check("top_oe_n", 32'(sram_oe_n), 32'd0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
